// File: rtl/uart_fifo_ctrl_if.sv
// Wishbone-side register bus bundle for uart_fifo_ctrl.
// Signal names match the original flat ports so existing decode logic maps one-to-one.
interface uart_fifo_ctrl_if;
  logic        i_wb_valid;
  logic [31:0] i_wb_adr;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;

  modport master (
    output i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
    input  o_wb_ack, o_wb_dat
  );

  modport slave (
    input  i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
    output o_wb_ack, o_wb_dat
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// UART register controller: RX/TX FIFOs, level/status reporting, sticky errors,
// maskable level interrupt and a TX launcher that drains the TX FIFO into the transmitter.
module uart_fifo_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned TX_DEPTH  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_fifo_ctrl_if.slave   wb,
  input  logic [DATA_W-1:0] i_rx,
  input  logic              i_irq,
  input  logic              i_rx_busy,
  input  logic              i_frame_err,
  output logic              o_rx_finish,
  output logic [DATA_W-1:0] o_tx,
  output logic              o_tx_start,
  input  logic              i_tx_start_clear,
  input  logic              i_tx_busy,
  output logic              o_irq
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_LW = RX_AW + 1;
  localparam int unsigned TX_LW = TX_AW + 1;
  localparam logic [RX_LW-1:0] RX_FULL_LVL = RX_LW'(RX_DEPTH);
  localparam logic [TX_LW-1:0] TX_FULL_LVL = TX_LW'(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_e;

  tx_state_e tx_state;

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [RX_AW-1:0]  rx_wr, rx_rd;
  logic [TX_AW-1:0]  tx_wr, tx_rd;
  logic [RX_LW-1:0]  rx_cnt;
  logic [TX_LW-1:0]  tx_cnt;
  logic [2:0]        ctrl;
  logic              ovr, ferr, txovf;

  logic        bus_fire, hit;
  logic [1:0]  off;
  logic        rd_rx, rd_stat, wr_tx, wr_ctrl_lo, wr_ctrl_hi;
  logic        rx_flush, tx_flush;
  logic        rx_empty, rx_full, tx_empty, tx_full, tx_active;
  logic        rx_good, rx_push, rx_pop, tx_push, tx_pop;
  logic        ovr_set, ferr_set, txovf_set;
  logic [7:0]  rx_lvl, tx_lvl;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign unused_ok = ^{wb.i_wb_adr[1:0], wb.i_wb_dat, wb.i_wb_sel[3:2], i_rx_busy};

  // Every side effect is qualified by bus_fire, i.e. the cycle o_wb_ack is being raised.
  assign bus_fire   = wb.i_wb_valid & ~wb.o_wb_ack;
  assign hit        = (wb.i_wb_adr[31:4] == BASE_ADDR[31:4]);
  assign off        = wb.i_wb_adr[3:2];
  assign rd_rx      = bus_fire & hit & ~wb.i_wb_we & (off == 2'd0);
  assign rd_stat    = bus_fire & hit & ~wb.i_wb_we & (off == 2'd2);
  assign wr_tx      = bus_fire & hit & wb.i_wb_we & (off == 2'd1) & wb.i_wb_sel[0];
  assign wr_ctrl_lo = bus_fire & hit & wb.i_wb_we & (off == 2'd3) & wb.i_wb_sel[0];
  assign wr_ctrl_hi = bus_fire & hit & wb.i_wb_we & (off == 2'd3) & wb.i_wb_sel[1];
  assign rx_flush   = wr_ctrl_hi & wb.i_wb_dat[8];
  assign tx_flush   = wr_ctrl_hi & wb.i_wb_dat[9];

  assign rx_empty  = (rx_cnt == '0);
  assign rx_full   = (rx_cnt == RX_FULL_LVL);
  assign tx_empty  = (tx_cnt == '0);
  assign tx_full   = (tx_cnt == TX_FULL_LVL);
  assign tx_active = (tx_state != TX_IDLE);
  assign rx_lvl    = 8'(rx_cnt);
  assign tx_lvl    = 8'(tx_cnt);

  // A pop in the same cycle frees the slot, so a full RX FIFO still accepts the push.
  assign rx_pop    = rd_rx & ~rx_empty;
  assign rx_good   = i_irq & ~i_frame_err;
  assign rx_push   = rx_good & (~rx_full | rx_pop);
  assign ovr_set   = rx_good & rx_full & ~rx_pop;
  assign ferr_set  = i_irq & i_frame_err;
  assign tx_push   = wr_tx & ~tx_full;
  assign txovf_set = wr_tx & tx_full;
  assign tx_pop    = (tx_state == TX_IDLE) & ~tx_empty & ~i_tx_busy & ~tx_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (rx_pop & ~rx_push) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push & ~rx_flush) rx_mem[rx_wr] <= i_rx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (tx_pop & ~tx_push) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push & ~tx_flush) tx_mem[tx_wr] <= wb.i_wb_dat[DATA_W-1:0];
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (off)
        2'd0: if (!rx_empty) rd_data[DATA_W-1:0] = rx_mem[rx_rd];
        2'd2: rd_data = {8'h00, tx_lvl, rx_lvl, tx_active, txovf, ferr, ovr,
                         tx_full, tx_empty, rx_full, rx_empty};
        2'd3: rd_data = {29'd0, ctrl};
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_dat <= '0;
    end else begin
      wb.o_wb_ack <= bus_fire;
      wb.o_wb_dat <= (bus_fire & ~wb.i_wb_we) ? rd_data : '0;
    end
  end

  // A sticky event coinciding with the clearing STAT read still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl        <= '0;
      ovr         <= 1'b0;
      ferr        <= 1'b0;
      txovf       <= 1'b0;
      o_irq       <= 1'b0;
      o_rx_finish <= 1'b0;
    end else begin
      if (wr_ctrl_lo) ctrl <= wb.i_wb_dat[2:0];
      ovr         <= ovr_set   | (ovr   & ~rd_stat);
      ferr        <= ferr_set  | (ferr  & ~rd_stat);
      txovf       <= txovf_set | (txovf & ~rd_stat);
      o_irq       <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_active) |
                     (ctrl[2] & (ovr | ferr | txovf));
      o_rx_finish <= i_irq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      o_tx       <= '0;
      o_tx_start <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          o_tx       <= tx_mem[tx_rd];
          o_tx_start <= 1'b1;
          tx_state   <= TX_LOAD;
        end
        TX_LOAD: if (i_tx_start_clear) begin
          o_tx_start <= 1'b0;
          tx_state   <= TX_WAIT;
        end
        TX_WAIT: if (!i_tx_busy) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
